// File: rtl/alu_issue_ctrl.sv
// Issue stage for the 4-DSP complex ALU: instruction FIFO, opcode decode, operand skew, result tracking.
// Latency: opcode/config 1 cycle after push into an empty FIFO; operands OPERAND_SKEW later; res_valid ALU_LATENCY after issue.
// Backpressure: in_ready drops only when the FIFO is full; the ALU side never stalls, so one entry is popped every non-empty cycle.
module alu_issue_ctrl #(
  parameter int FIFO_DEPTH   = 4,
  parameter int OPERAND_SKEW = 2,
  parameter int ALU_LATENCY  = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    in_opcode,
  input  logic [31:0]                   in_din_1,
  input  logic [31:0]                   in_din_2,
  input  logic [31:0]                   in_din_3,
  output logic [2:0]                    opcode,
  output logic [15:0]                   alumode,
  output logic [19:0]                   inmode,
  output logic [27:0]                   opmode,
  output logic [3:0]                    cea2,
  output logic [3:0]                    ceb2,
  output logic [3:0]                    usemult,
  output logic [31:0]                   din_1,
  output logic [31:0]                   din_2,
  output logic [31:0]                   din_3,
  output logic                          res_valid,
  output logic [2:0]                    res_opcode,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = 3 + 3 * 32;

  // Per-DSP mode words: multiplier only, or multiplier plus the C port accumulate input.
  localparam logic [6:0] OPM_M    = 7'b0000101;
  localparam logic [6:0] OPM_CM   = 7'b0110101;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_ZSUB = 4'b0011;

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] head;
  logic [2:0]       head_op;

  logic [2:0]       nxt_op;
  logic [15:0]      nxt_alumode;
  logic [27:0]      nxt_opmode;
  logic [3:0]       nxt_ce;
  logic [31:0]      nxt_d1;
  logic [31:0]      nxt_d2;
  logic [31:0]      nxt_d3;

  logic [31:0]      iss_d1;
  logic [31:0]      iss_d2;
  logic [31:0]      iss_d3;
  logic [95:0]      skew [OPERAND_SKEW];

  logic [ALU_LATENCY-1:0] vld_pipe;
  logic [2:0]             op_pipe [ALU_LATENCY];

  assign in_ready   = (level < LVL_W'(FIFO_DEPTH));
  assign push       = in_valid & in_ready;
  assign pop        = (level != '0);
  assign fifo_level = level;
  assign head       = mem[rd_ptr];
  assign head_op    = head[ENT_W-1 -: 3];
  // INMODE is zero for every supported operation.
  assign inmode     = '0;

  // FIFO storage; contents are don't-care until the level says otherwise, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_opcode, in_din_1, in_din_2, in_din_3};
  end

  // FIFO pointers and occupancy; pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Decode the FIFO head; an empty FIFO or a 0xx opcode both issue an all-zero NOP.
  always_comb begin
    nxt_op      = 3'b000;
    nxt_alumode = '0;
    nxt_opmode  = '0;
    nxt_ce      = 4'b0000;
    nxt_d1      = '0;
    nxt_d2      = '0;
    nxt_d3      = '0;
    if (pop && head_op[2]) begin
      nxt_op = head_op;
      nxt_ce = 4'b1111;
      nxt_d1 = head[95:64];
      nxt_d2 = head[63:32];
      nxt_d3 = head[31:0];
      case (head_op[1:0])
        2'b01: nxt_opmode = {OPM_CM, OPM_M, OPM_CM, OPM_M};
        2'b10: begin
          nxt_opmode  = {OPM_CM, OPM_M, OPM_CM, OPM_M};
          nxt_alumode = {ALU_ADD, ALU_ZSUB, ALU_ADD, ALU_ZSUB};
        end
        default: nxt_opmode = {4{OPM_M}};
      endcase
    end
  end

  // Issue register: opcode and config go to the ALU, operands enter the skew line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode  <= 3'b000;
      alumode <= '0;
      opmode  <= '0;
      cea2    <= '0;
      ceb2    <= '0;
      usemult <= '0;
      iss_d1  <= '0;
      iss_d2  <= '0;
      iss_d3  <= '0;
    end else begin
      opcode  <= nxt_op;
      alumode <= nxt_alumode;
      opmode  <= nxt_opmode;
      cea2    <= nxt_ce;
      ceb2    <= nxt_ce;
      usemult <= nxt_ce;
      iss_d1  <= nxt_d1;
      iss_d2  <= nxt_d2;
      iss_d3  <= nxt_d3;
    end
  end

  // Operand skew line: OPERAND_SKEW stages after the issue register, one value per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OPERAND_SKEW; i++) skew[i] <= '0;
    end else begin
      skew[0] <= {iss_d1, iss_d2, iss_d3};
      for (int i = 1; i < OPERAND_SKEW; i++) skew[i] <= skew[i-1];
    end
  end

  assign din_1 = skew[OPERAND_SKEW-1][95:64];
  assign din_2 = skew[OPERAND_SKEW-1][63:32];
  assign din_3 = skew[OPERAND_SKEW-1][31:0];

  // Result tracker: follows the issued opcode down the ALU pipeline; NOPs carry opcode 000 and no valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int i = 0; i < ALU_LATENCY; i++) op_pipe[i] <= 3'b000;
    end else begin
      vld_pipe <= {vld_pipe[ALU_LATENCY-2:0], opcode[2]};
      op_pipe[0] <= opcode;
      for (int i = 1; i < ALU_LATENCY; i++) op_pipe[i] <= op_pipe[i-1];
    end
  end

  assign res_valid  = vld_pipe[ALU_LATENCY-1];
  assign res_opcode = op_pipe[ALU_LATENCY-1];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: random and directed instruction streams against a cycle-indexed reference model.
// Expected issue/operand/result events are queued at push time; a negedge monitor pops and compares.
// Input side is driven with valid held until ready; the DUT has no output backpressure.
module tb_alu_issue_ctrl;

  localparam int DEPTH = 4;
  localparam int SKEW  = 2;
  localparam int LAT   = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_opcode = '0;
  logic [31:0] in_din_1 = '0, in_din_2 = '0, in_din_3 = '0;
  logic [2:0]  opcode;
  logic [15:0] alumode;
  logic [19:0] inmode;
  logic [27:0] opmode;
  logic [3:0]  cea2, ceb2, usemult;
  logic [31:0] din_1, din_2, din_3;
  logic        res_valid;
  logic [2:0]  res_opcode;
  logic [2:0]  fifo_level;

  alu_issue_ctrl #(.FIFO_DEPTH(DEPTH), .OPERAND_SKEW(SKEW), .ALU_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_din_1(in_din_1), .in_din_2(in_din_2), .in_din_3(in_din_3),
    .opcode(opcode), .alumode(alumode), .inmode(inmode), .opmode(opmode),
    .cea2(cea2), .ceb2(ceb2), .usemult(usemult),
    .din_1(din_1), .din_2(din_2), .din_3(din_3),
    .res_valid(res_valid), .res_opcode(res_opcode), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          e;
    int          p;
    logic [2:0]  op;
    logic [31:0] d1, d2, d3;
  } rec_t;

  rec_t iss_q[$];
  rec_t opd_q[$];
  rec_t res_q[$];

  int n_chk  = 0;
  int n_fail = 0;
  int edge_cnt = 0;
  int last_issue = -100;
  bit done = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got 0x%0h expected 0x%0h", name, edge_cnt, act, exp);
    end
  endtask

  // Reference decode, per DSP (d=1..4, DSP1 packed in the most significant field).
  function automatic void ref_decode(input logic [2:0] op, output logic [15:0] alu,
                                     output logic [27:0] opm, output logic [3:0] ce);
    alu = '0; opm = '0; ce = '0;
    if (op >= 3'd4) begin
      ce = 4'b1111;
      for (int d = 1; d <= 4; d++) begin
        logic [6:0] om;
        logic [3:0] am;
        om = ((op == 3'd5 || op == 3'd6) && (d % 2 == 1)) ? 7'b0110101 : 7'b0000101;
        am = (op == 3'd6 && (d % 2 == 0)) ? 4'b0011 : 4'b0000;
        opm[(4-d)*7 +: 7] = om;
        alu[(4-d)*4 +: 4] = am;
      end
    end
  endfunction

  // Monitor: every negedge, compare outputs against whatever the model scheduled for this edge.
  always @(negedge clk) begin
    if (!done) begin
      int m;
      int lvl;
      logic [2:0]  e_op;
      logic [15:0] e_alu;
      logic [27:0] e_opm;
      logic [3:0]  e_ce;
      logic [31:0] e1, e2, e3;
      logic        e_rv;
      logic [2:0]  e_ro;
      m = edge_cnt;
      e_op = '0; e1 = '0; e2 = '0; e3 = '0; e_rv = 1'b0; e_ro = '0;
      if (iss_q.size() > 0 && iss_q[0].e <= m) begin
        if (iss_q[0].e < m) chk("issue_missed_edge", iss_q[0].e, m);
        e_op = iss_q[0].op[2] ? iss_q[0].op : 3'b000;
        void'(iss_q.pop_front());
      end
      ref_decode(e_op, e_alu, e_opm, e_ce);
      if (opd_q.size() > 0 && opd_q[0].e == m) begin
        e1 = opd_q[0].d1; e2 = opd_q[0].d2; e3 = opd_q[0].d3;
        void'(opd_q.pop_front());
      end
      if (res_q.size() > 0 && res_q[0].e == m) begin
        e_rv = 1'b1; e_ro = res_q[0].op;
        void'(res_q.pop_front());
      end
      lvl = 0;
      foreach (iss_q[i]) if (iss_q[i].p <= m) lvl++;
      chk("opcode", 32'(opcode), 32'(e_op));
      chk("alumode", 32'(alumode), 32'(e_alu));
      chk("opmode", 32'(opmode), 32'(e_opm));
      chk("inmode", 32'(inmode), 32'd0);
      chk("cea2", 32'(cea2), 32'(e_ce));
      chk("ceb2", 32'(ceb2), 32'(e_ce));
      chk("usemult", 32'(usemult), 32'(e_ce));
      chk("din_1", din_1, e1);
      chk("din_2", din_2, e2);
      chk("din_3", din_3, e3);
      chk("res_valid", 32'(res_valid), 32'(e_rv));
      chk("res_opcode", 32'(res_opcode), 32'(e_ro));
      chk("fifo_level", 32'(fifo_level), 32'(lvl));
      chk("in_ready", 32'(in_ready), 32'(lvl < DEPTH));
    end
  end

  // Present one instruction (called at a negedge); returns at the following negedge with valid still high.
  task automatic send(input logic [2:0] op, input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3);
    int guard;
    int p;
    int iss;
    rec_t r;
    in_valid = 1'b1; in_opcode = op; in_din_1 = d1; in_din_2 = d2; in_din_3 = d3;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    p = edge_cnt + 1;
    @(posedge clk);
    // Model: one pop per edge while non-empty, earliest one edge after the push.
    iss = (p + 1 > last_issue + 1) ? p + 1 : last_issue + 1;
    last_issue = iss;
    r.p = p; r.op = op; r.d1 = d1; r.d2 = d2; r.d3 = d3;
    r.e = iss;
    iss_q.push_back(r);
    if (op[2]) begin
      r.e = iss + SKEW;
      opd_q.push_back(r);
      r.e = iss + LAT;
      res_q.push_back(r);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Asynchronous reset mid-cycle: outputs must clear before the next clock edge.
  task automatic mid_reset();
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_async_opcode", 32'(opcode), 32'd0);
    chk("rst_async_cea2", 32'(cea2), 32'd0);
    chk("rst_async_din_1", din_1, 32'd0);
    chk("rst_async_res_valid", 32'(res_valid), 32'd0);
    chk("rst_async_level", 32'(fifo_level), 32'd0);
    chk("rst_async_in_ready", 32'(in_ready), 32'd1);
    iss_q.delete(); opd_q.delete(); res_q.delete();
    last_issue = -100;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single MUL of two Q15 0.5 values.
    send(3'd4, 32'h4000_4000, 32'h4000_4000, 32'h0);
    idle(12);

    // Six back-to-back MULs.
    for (int i = 0; i < 6; i++) send(3'd4, 32'h1000 * (i + 1), 32'h0101 * (i + 1), 32'(i));
    idle(12);

    // Directed decode: MULSUB, MAX, NOP-class, MULADD back to back.
    send(3'd6, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666);
    send(3'd7, 32'h7fff_8000, 32'h0001_ffff, 32'h0);
    send(3'd2, 32'hdead_beef, 32'hcafe_f00d, 32'h1234_5678);
    send(3'd5, 32'h0a0a_0b0b, 32'h0c0c_0d0d, 32'h0e0e_0f0f);
    idle(12);

    // Sparse issue with empty gaps between instructions.
    for (int i = 0; i < 6; i++) begin
      send(3'd4 + 3'(i % 4), $urandom, $urandom, $urandom);
      idle(1 + (i % 3));
    end
    idle(10);

    // Random stream with random gaps and random opcodes including NOP-class.
    for (int i = 0; i < 150; i++) begin
      send(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    // Reset with work in flight; nothing may emerge afterwards.
    send(3'd4, $urandom, $urandom, $urandom);
    send(3'd5, $urandom, $urandom, $urandom);
    send(3'd6, $urandom, $urandom, $urandom);
    mid_reset();
    idle(10);

    // Traffic after reset.
    for (int i = 0; i < 20; i++) send(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
    idle(15);

    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected completion before 200000");
    $fatal(1);
  end

endmodule
